// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - keypad sequencer for the calculator ALU
// Collects operand A, operator, operand B, runs the ALU for one cycle on '=' and shows the result.
module calc_sequencer #(
  parameter int MAX_OPERAND = 255,
  parameter bit CHAIN_EN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  output logic        o_key_ready,
  output logic [7:0]  o_alu_a,
  output logic [7:0]  o_alu_b,
  output logic [1:0]  o_alu_op,
  input  logic [15:0] i_alu_result,
  input  logic        i_alu_neg,
  output logic [15:0] o_disp_value,
  output logic        o_disp_neg,
  output logic        o_err,
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_EXEC    = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  localparam logic [3:0] K_EQ  = 4'hD;
  localparam logic [3:0] K_CLR = 4'hE;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_a, w_a_nx;
  logic [7:0]  r_b, w_b_nx;
  logic [1:0]  r_op, w_op_nx;
  logic [15:0] r_disp, w_disp_nx;
  logic        r_disp_neg, w_disp_neg_nx;
  logic        r_done, w_done_nx;
  logic        r_b_seen, w_b_seen_nx;

  logic        w_accept;
  logic        w_is_digit;
  logic        w_is_op;
  logic [1:0]  w_op_code;
  logic [11:0] w_acc_a;
  logic [11:0] w_acc_b;
  logic        w_ovf_a;
  logic        w_ovf_b;
  logic        w_chain_ok;

  assign o_key_ready  = (r_state != S_EXEC);
  assign o_alu_a      = r_a;
  assign o_alu_b      = r_b;
  assign o_alu_op     = r_op;
  assign o_disp_value = r_disp;
  assign o_disp_neg   = r_disp_neg;
  assign o_err        = (r_state == S_ERROR);
  assign o_done       = r_done;

  assign w_accept   = i_key_valid && o_key_ready;
  assign w_is_digit = (i_key_code <= 4'd9);
  assign w_is_op    = (i_key_code >= 4'hA) && (i_key_code <= 4'hC);
  assign w_op_code  = 2'(i_key_code - 4'hA);

  // 12 bits holds the worst case 255*10+9 without wrapping.
  assign w_acc_a    = ({4'd0, r_a} * 12'd10) + {8'd0, i_key_code};
  assign w_acc_b    = ({4'd0, r_b} * 12'd10) + {8'd0, i_key_code};
  assign w_ovf_a    = (w_acc_a > 12'(MAX_OPERAND));
  assign w_ovf_b    = (w_acc_b > 12'(MAX_OPERAND));
  assign w_chain_ok = !r_disp_neg && (r_disp <= 16'(MAX_OPERAND));

  always_comb begin
    w_state_nx    = r_state;
    w_a_nx        = r_a;
    w_b_nx        = r_b;
    w_op_nx       = r_op;
    w_disp_nx     = r_disp;
    w_disp_neg_nx = r_disp_neg;
    w_done_nx     = 1'b0;
    w_b_seen_nx   = r_b_seen;

    if (w_accept && i_key_code == K_CLR) begin
      w_state_nx    = S_ENTER_A;
      w_a_nx        = 8'd0;
      w_b_nx        = 8'd0;
      w_op_nx       = 2'd0;
      w_disp_nx     = 16'd0;
      w_disp_neg_nx = 1'b0;
      w_b_seen_nx   = 1'b0;
    end else begin
      case (r_state)
        S_ENTER_A: begin
          if (w_accept && w_is_digit) begin
            if (w_ovf_a) begin
              w_state_nx    = S_ERROR;
              w_disp_nx     = 16'd0;
              w_disp_neg_nx = 1'b0;
            end else begin
              w_a_nx    = w_acc_a[7:0];
              w_disp_nx = {4'd0, w_acc_a};
            end
          end else if (w_accept && w_is_op) begin
            w_op_nx     = w_op_code;
            w_b_nx      = 8'd0;
            w_b_seen_nx = 1'b0;
            w_state_nx  = S_ENTER_B;
          end
        end
        S_ENTER_B: begin
          if (w_accept && w_is_digit) begin
            if (w_ovf_b) begin
              w_state_nx    = S_ERROR;
              w_disp_nx     = 16'd0;
              w_disp_neg_nx = 1'b0;
            end else begin
              w_b_nx      = w_acc_b[7:0];
              w_b_seen_nx = 1'b1;
              w_disp_nx   = {4'd0, w_acc_b};
            end
          end else if (w_accept && w_is_op && !r_b_seen) begin
            w_op_nx = w_op_code;
          end else if (w_accept && i_key_code == K_EQ && r_b_seen) begin
            w_state_nx = S_EXEC;
          end
        end
        S_EXEC: begin
          w_disp_nx     = i_alu_result;
          w_disp_neg_nx = i_alu_neg;
          w_done_nx     = 1'b1;
          w_state_nx    = S_DONE;
        end
        S_DONE: begin
          if (w_accept && w_is_digit) begin
            w_a_nx        = {4'd0, i_key_code};
            w_disp_nx     = {12'd0, i_key_code};
            w_disp_neg_nx = 1'b0;
            w_state_nx    = S_ENTER_A;
          end else if (w_accept && w_is_op && CHAIN_EN) begin
            if (w_chain_ok) begin
              w_a_nx      = r_disp[7:0];
              w_op_nx     = w_op_code;
              w_b_nx      = 8'd0;
              w_b_seen_nx = 1'b0;
              w_state_nx  = S_ENTER_B;
            end else begin
              w_state_nx    = S_ERROR;
              w_disp_nx     = 16'd0;
              w_disp_neg_nx = 1'b0;
            end
          end
        end
        S_ERROR: begin
          w_disp_nx     = 16'd0;
          w_disp_neg_nx = 1'b0;
        end
        default: w_state_nx = S_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_ENTER_A;
      r_a        <= 8'd0;
      r_b        <= 8'd0;
      r_op       <= 2'd0;
      r_disp     <= 16'd0;
      r_disp_neg <= 1'b0;
      r_done     <= 1'b0;
      r_b_seen   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_a        <= w_a_nx;
      r_b        <= w_b_nx;
      r_op       <= w_op_nx;
      r_disp     <= w_disp_nx;
      r_disp_neg <= w_disp_neg_nx;
      r_done     <= w_done_nx;
      r_b_seen   <= w_b_seen_nx;
    end
  end

endmodule
